// File: rtl/alu_mc_if.sv
// Request/response bundle between a requester and the multi-cycle ALU.
interface alu_mc_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op_select;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op_select, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op_select, op_a, op_b, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, shift-add MUL
// taking WIDTH iterations, valid/ready handshake on both sides.
//
//   state  | meaning
//   IDLE   | no result held, ready for a request
//   BUSY   | MUL in progress, one shift-add step per cycle
//   DONE   | result/flags presented, waiting for out_ready
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_PA   = 3'b011;
  localparam logic [2:0] OP_PB   = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_SHR  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic                 accept;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [WIDTH-1:0]     alu_res;
  logic [3:0]           alu_flg;
  logic                 alu_c;
  logic                 alu_v;
  logic [WIDTH:0]       sum_w;
  logic [WIDTH:0]       diff_w;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;
  logic [SHW-1:0]       amt;

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign amt           = bus.op_b[SHW-1:0];
  assign prod_nxt      = prod_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ops: result and flags straight from the request operands.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    // Widened by one bit so the top bit is the carry / borrow / shifted-out bit.
    sum_w   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    diff_w  = {1'b0, bus.op_a} - {1'b0, bus.op_b};
    shl_w   = {1'b0, bus.op_a} << amt;
    shr_w   = {bus.op_a, 1'b0} >> amt;
    case (bus.op_select)
      OP_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      OP_NAND: alu_res = ~(bus.op_a & bus.op_b);
      OP_PA:   alu_res = bus.op_a;
      OP_PB:   alu_res = bus.op_b;
      OP_SHL: begin
        alu_res = shl_w[WIDTH-1:0];
        alu_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_w[WIDTH:1];
        alu_c   = shr_w[0];
      end
      default: alu_res = '0;
    endcase
    alu_flg = {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // Next-state and datapath update: accept, MUL iteration, retire.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if ((state_q == S_DONE) && bus.out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (bus.op_select == OP_MUL) begin
            state_d  = S_BUSY;
            mcand_d  = {{WIDTH{1'b0}}, bus.op_a};
            mplier_d = bus.op_b;
            prod_d   = '0;
            cnt_d    = SHW'(WIDTH - 1);
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            flags_d  = alu_flg;
          end
        end
      end
      S_BUSY: begin
        prod_d   = prod_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = prod_nxt[WIDTH-1:0];
          flags_d  = {1'b0, (|prod_nxt[2*WIDTH-1:WIDTH]), prod_nxt[WIDTH-1],
                      ~(|prod_nxt[WIDTH-1:0])};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight or held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
